// File: rtl/score_event_writer.sv
// Write initiator for the score display: queues per-player point pulses and
// issues one spaced increment write per point, freezing once the match is over.
module score_event_writer #(
    parameter int PEND_W = 3,
    parameter int GAP    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic point_p1,
    input  logic point_p2,
    input  logic match_over,
    input  logic clear,
    output logic sel,
    output logic addr,
    output logic data_in,
    output logic busy,
    output logic game_over,
    output logic overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [3:0]        GAP_LD   = 4'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP,
        ST_HALT
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        gap_reg, gap_next;
    logic              rr_reg, rr_next;
    logic [PEND_W-1:0] pend_reg  [2];
    logic [PEND_W-1:0] pend_next [2];
    logic              sel_reg, addr_reg, busy_reg, game_over_reg, overflow_reg;

    logic [1:0] point_vec;
    logic [1:0] inc;
    logic [1:0] dec;
    logic [1:0] drop;
    logic       has1, has2;
    logic       choose_p;
    logic       go_write;
    logic       wr_player;
    logic       enter_halt;
    logic       overflow_next;
    logic       busy_next;

    assign point_vec = {point_p2, point_p1};
    assign has1      = (pend_reg[0] != '0);
    assign has2      = (pend_reg[1] != '0);
    // With both players waiting the pointer arbitrates; otherwise the lone waiter wins.
    assign choose_p  = (has1 && has2) ? rr_reg : has2;

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        rr_next    = rr_reg;
        go_write   = 1'b0;
        wr_player  = addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (match_over) begin
                    state_next = ST_HALT;
                end else if (has1 || has2) begin
                    go_write = 1'b1;
                end
            end
            ST_WRITE: begin
                state_next = ST_GAP;
                gap_next   = GAP_LD;
            end
            ST_GAP: begin
                if (gap_reg == 4'd1) begin
                    if (match_over) begin
                        state_next = ST_HALT;
                    end else if (has1 || has2) begin
                        go_write = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    gap_next = gap_reg - 4'd1;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (go_write) begin
            state_next = ST_WRITE;
            wr_player  = choose_p;
            if (has1 && has2) begin
                rr_next = ~rr_reg;
            end
        end
        if (clear) begin
            state_next = ST_IDLE;
            rr_next    = 1'b0;
            go_write   = 1'b0;
            wr_player  = addr_reg;
        end
    end

    assign enter_halt = (state_next == ST_HALT) && (state_reg != ST_HALT);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pend
            assign inc[gi]  = point_vec[gi] && (state_reg != ST_HALT) && !clear;
            assign dec[gi]  = go_write && (wr_player == 1'(gi));
            // A simultaneous decrement frees a slot, so a saturated counter only drops without one.
            assign drop[gi] = inc[gi] && !dec[gi] && (pend_reg[gi] == PEND_MAX);
            assign pend_next[gi] =
                (clear || enter_halt)           ? '0 :
                (inc[gi] && !dec[gi] && !drop[gi]) ? pend_reg[gi] + 1'b1 :
                (dec[gi] && !inc[gi])           ? pend_reg[gi] - 1'b1 :
                                                  pend_reg[gi];
        end
    endgenerate

    assign overflow_next = clear ? 1'b0 : (overflow_reg | drop[0] | drop[1]);
    assign busy_next     = (pend_next[0] != '0) || (pend_next[1] != '0) ||
                           (state_next == ST_WRITE) || (state_next == ST_GAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            gap_reg       <= '0;
            rr_reg        <= 1'b0;
            pend_reg[0]   <= '0;
            pend_reg[1]   <= '0;
            sel_reg       <= 1'b0;
            addr_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            game_over_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            gap_reg       <= gap_next;
            rr_reg        <= rr_next;
            pend_reg[0]   <= pend_next[0];
            pend_reg[1]   <= pend_next[1];
            sel_reg       <= (state_next == ST_WRITE);
            addr_reg      <= wr_player;
            busy_reg      <= busy_next;
            game_over_reg <= (state_next == ST_HALT);
            overflow_reg  <= overflow_next;
        end
    end

    assign sel       = sel_reg;
    assign data_in   = sel_reg;
    assign addr      = addr_reg;
    assign busy      = busy_reg;
    assign game_over = game_over_reg;
    assign overflow  = overflow_reg;

endmodule
